// File: rtl/sha256_padder_pkg.sv
// sha256_padder_pkg: shared types and helpers for the SHA-256 message padder.
//   state_t     : padder FSM states
//   BLOCK_WORDS : 32-bit words per 512-bit block
//   PAD_WORD    : a word holding only the 0x80 terminator byte
//   pad_word()  : keeps the valid leading bytes of a partial word and inserts 0x80
package sha256_padder_pkg;

  typedef enum logic {ST_FILL, ST_EMIT} state_t;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  // bytes is the number of valid MSB-aligned bytes (0-3); the byte right after
  // them becomes 0x80 and everything below is cleared.
  function automatic logic [31:0] pad_word(input logic [31:0] data,
                                           input logic [2:0]  bytes);
    case (bytes)
      3'd0:    pad_word = PAD_WORD;
      3'd1:    pad_word = {data[31:24], 24'h80_0000};
      3'd2:    pad_word = {data[31:16], 16'h8000};
      3'd3:    pad_word = {data[31:8],  8'h80};
      default: pad_word = data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// sha256_padder_if: message word stream in, padded 512-bit block stream out.
//   in_valid/in_ready/in_data/in_bytes/in_last : 32-bit big-endian message beats
//   blk_valid/blk_ready/blk_data/blk_first/blk_last : padded blocks
//   modport slave  : padder side
//   modport master : producer/consumer side
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport master (
    output in_valid, in_data, in_bytes, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: collects 32-bit message words into 512-bit blocks and applies
// FIPS 180-4 padding (0x80 terminator, zero fill, 64-bit bit length).
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   s       : word stream in / block stream out (sha256_padder_if.slave)
//   o_err   : sticky protocol error (bad in_bytes), cleared only by reset
module sha256_padder
  import sha256_padder_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  sha256_padder_if.slave  s,
  output logic            o_err
);

  state_t             r_state;
  logic [3:0]         r_w;          // next word slot to fill
  logic [60:0]        r_cnt;        // message byte count
  logic               r_pend;       // a length-only extra block must follow
  logic               r_extra_w0;   // extra block starts with the 0x80 word
  logic               r_first_flag; // next block opens a message
  logic [15:0][31:0]  r_buf;
  logic               r_blk_first;
  logic               r_blk_last;
  logic               r_err;

  logic               w_beat;
  logic               w_bad;
  logic [2:0]         w_b;
  logic [60:0]        w_cnt_nxt;
  logic [63:0]        w_bitlen;
  logic [4:0]         w_p;
  logic [31:0]        w_pw;
  logic [15:0][31:0]  w_blk;

  assign s.in_ready  = (r_state == ST_FILL) && !i_reset;
  assign s.blk_valid = (r_state == ST_EMIT);
  assign s.blk_data  = r_buf;
  assign s.blk_first = r_blk_first;
  assign s.blk_last  = r_blk_last;
  assign o_err       = r_err;

  assign w_beat = s.in_valid && s.in_ready;
  // Only the last beat may be short, and never more than 4 bytes.
  assign w_bad  = (!s.in_last && s.in_bytes != 3'd4) || (s.in_bytes > 3'd4);
  assign w_b    = w_bad ? 3'd4 : s.in_bytes;

  assign w_cnt_nxt = r_cnt + 61'(w_b);
  assign w_bitlen  = {w_cnt_nxt, 3'b000};
  // Word that receives the 0x80 byte; 16 means it spills into the extra block.
  assign w_p       = (w_b == 3'd4) ? ({1'b0, r_w} + 5'd1) : {1'b0, r_w};
  assign w_pw      = (w_b == 3'd4) ? s.in_data : pad_word(s.in_data, w_b);

  // Final block image for a last beat landing in slot r_w.
  always_comb begin
    w_blk = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (5'(i) < {1'b0, r_w})       w_blk[i] = r_buf[i];
      else if (5'(i) == {1'b0, r_w}) w_blk[i] = w_pw;
      else if (5'(i) == w_p)         w_blk[i] = PAD_WORD;
      else                           w_blk[i] = 32'h0;
    end
    if (w_p <= 5'd13) begin
      w_blk[14] = w_bitlen[63:32];
      w_blk[15] = w_bitlen[31:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_FILL;
      r_w          <= '0;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_extra_w0   <= 1'b0;
      r_first_flag <= 1'b1;
      r_buf        <= '0;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_beat && w_bad) r_err <= 1'b1;
      case (r_state)
        ST_FILL: if (w_beat) begin
          r_cnt <= w_cnt_nxt;
          if (s.in_last) begin
            r_buf       <= w_blk;
            r_state     <= ST_EMIT;
            r_blk_first <= r_first_flag;
            r_blk_last  <= (w_p <= 5'd13);
            r_pend      <= (w_p > 5'd13);
            r_extra_w0  <= (w_p == 5'd16);
          end else begin
            r_buf[r_w] <= s.in_data;
            if (r_w == 4'd15) begin
              r_state     <= ST_EMIT;
              r_blk_first <= r_first_flag;
              r_blk_last  <= 1'b0;
            end else begin
              r_w <= r_w + 4'd1;
            end
          end
        end
        ST_EMIT: if (s.blk_ready) begin
          if (r_pend) begin
            // Length block; r_cnt already holds the full message count.
            r_buf       <= '0;
            r_buf[0]    <= r_extra_w0 ? PAD_WORD : 32'h0;
            r_buf[14]   <= {r_cnt, 3'b000} >> 32;
            r_buf[15]   <= r_cnt[28:0] << 3;
            r_blk_first <= 1'b0;
            r_blk_last  <= 1'b1;
            r_pend      <= 1'b0;
          end else begin
            r_state <= ST_FILL;
            r_w     <= '0;
            if (r_blk_last) begin
              r_cnt        <= '0;
              r_first_flag <= 1'b1;
            end else begin
              r_first_flag <= 1'b0;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sha256_padder_if ifc();
  sha256_padder dut (.i_clk(clk), .i_reset(rst), .s(ifc), .o_err(err));

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    pat = 32'hC0DE_0000 | 32'(i);
  endfunction

  // Block with pattern words in slots 0..n-1, zero elsewhere.
  function automatic logic [511:0] pat_blk(input int n);
    logic [15:0][31:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i] = pat(i);
    pat_blk = b;
  endfunction

  task automatic push(input logic [511:0] d, input logic f, input logic l);
    exp_t e;
    e.data = d; e.first = f; e.last = l;
    q.push_back(e);
  endtask

  // Scoreboard monitor: compare every block taken by the consumer.
  always @(negedge clk) begin
    if (!rst && ifc.blk_valid && ifc.blk_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_block act=%h", ifc.blk_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("blk_data",  ifc.blk_data,        e.data);
        chk("blk_first", 512'(ifc.blk_first), 512'(e.first));
        chk("blk_last",  512'(ifc.blk_last),  512'(e.last));
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    int cyc;
    ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_bytes = b; ifc.in_last = l;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ifc.in_ready) break;
      cyc++;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL in_ready_timeout act=0 exp=1");
        break;
      end
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_msg(input int nfull, input logic [31:0] ld, input logic [2:0] lb);
    for (int i = 0; i < nfull; i++) send_word(pat(i), 3'd4, 1'b0);
    send_word(ld, lb, 1'b1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (q.size() != 0 && cyc < 500) begin
      @(posedge clk); cyc++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0][31:0] b;
    logic [511:0] abc;
    int cyc;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_bytes = '0; ifc.in_last = 1'b0;
    ifc.blk_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 512'(ifc.in_ready), 512'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  512'(ifc.in_ready),  512'(1));
    chk("rst_blk_valid", 512'(ifc.blk_valid), 512'(0));
    chk("rst_blk_data",  ifc.blk_data,        512'(0));
    chk("rst_flags",     512'({ifc.blk_first, ifc.blk_last, err}), 512'(0));
    @(posedge clk); #1;

    // "abc"
    b = '0; b[0] = 32'h6162_6380; b[15] = 32'h0000_0018; abc = b;
    push(abc, 1'b1, 1'b1);
    send_msg(0, 32'h6162_6300, 3'd3);
    drain();

    // empty message
    b = '0; b[0] = 32'h8000_0000;
    push(b, 1'b1, 1'b1);
    send_msg(0, 32'h0, 3'd0);
    drain();

    // 55 bytes
    b = pat_blk(13); b[13] = 32'hDDEE_FF80; b[15] = 32'h0000_01B8;
    push(b, 1'b1, 1'b1);
    send_msg(13, 32'hDDEE_FF11, 3'd3);
    drain();

    // 56 bytes: pad lands in word 14, length spills to a second block
    b = pat_blk(14); b[14] = 32'h8000_0000;
    push(b, 1'b1, 1'b0);
    b = '0; b[15] = 32'h0000_01C0;
    push(b, 1'b0, 1'b1);
    send_msg(13, pat(13), 3'd4);
    drain();

    // 64 bytes: pad word opens the extra block
    push(pat_blk(16), 1'b1, 1'b0);
    b = '0; b[0] = 32'h8000_0000; b[15] = 32'h0000_0200;
    push(b, 1'b0, 1'b1);
    send_msg(15, pat(15), 3'd4);
    drain();

    // backpressure: block must hold for 5 cycles with input stalled
    ifc.blk_ready = 1'b0;
    push(abc, 1'b1, 1'b1);
    send_msg(0, 32'h6162_6300, 3'd3);
    cyc = 0;
    while (!ifc.blk_valid && cyc < 50) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_blk_valid", 512'(ifc.blk_valid), 512'(1));
      chk("bp_blk_data",  ifc.blk_data,        abc);
      chk("bp_in_ready",  512'(ifc.in_ready),  512'(0));
    end
    @(posedge clk); #1; ifc.blk_ready = 1'b1;
    drain();

    // reset mid-block discards the partial block
    for (int i = 0; i < 5; i++) send_word(pat(i), 3'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_blk_valid", 512'(ifc.blk_valid), 512'(0));
    chk("midrst_in_ready",  512'(ifc.in_ready),  512'(1));
    @(posedge clk); #1;
    push(abc, 1'b1, 1'b1);
    send_msg(0, 32'h6162_6300, 3'd3);
    drain();
    chk("err_clear", 512'(err), 512'(0));

    // non-last beat with 2 bytes: counted as 4, err sticks
    b = '0; b[0] = 32'h1122_3344; b[1] = 32'h4180_0000; b[15] = 32'h0000_0028;
    push(b, 1'b1, 1'b1);
    send_word(32'h1122_3344, 3'd2, 1'b0);
    send_word(32'h4100_0000, 3'd1, 1'b1);
    drain();
    chk("err_set", 512'(err), 512'(1));
    push(abc, 1'b1, 1'b1);
    send_msg(0, 32'h6162_6300, 3'd3);
    drain();
    chk("err_sticky", 512'(err), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
